// File: rtl/tt_um_umar316798.sv
// ---------------------------------------------------------------------------
// tt_um_umar316798 -- intrusion alarm in the Tiny Tapeout user wrapper.
//
// Three sensor inputs drive an instantaneous combinational alarm. Registered
// logic adds arming, a latched alarm with per-sensor cause flags, a blinking
// siren and a saturating count of alarm rising edges seen while armed.
//
// Ports:
//   clk      system clock, all registers update on its rising edge
//   rst_n    synchronous reset, ACTIVE HIGH despite the template name
//   ui_in    [0]=motion [1]=door [2]=window [3]=arm [4]=clear, [7:5] unused
//   uo_out   [0]=alarm_now [1]=alarm_latched [4:2]=window/door/motion cause
//            [5]=armed [6]=siren [7]=0
//   uio_in   unused
//   uio_out  trigger-event counter (saturates at 255)
//   uio_oe   constant 8'hFF (bidirectional pins always driven)
//   ena      unused, the design is always active
// ---------------------------------------------------------------------------
module tt_um_umar316798 #(
    parameter int BLINK_DIV = 4          // siren period is 2^BLINK_DIV cycles
) (
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe,
    input  logic       ena,
    input  logic       clk,
    input  logic       rst_n
);

    // The wrapper's "rst_n" is really an active-high synchronous reset.
    logic srst;
    assign srst = rst_n;

    logic [2:0] sensors;
    logic       arm_in;
    logic       clear_in;
    assign sensors  = ui_in[2:0];
    assign arm_in   = ui_in[3];
    assign clear_in = ui_in[4];

    // Inputs the design deliberately ignores.
    logic unused_inputs;
    assign unused_inputs = &{1'b0, uio_in, ena, ui_in[7:5]};

    // Instantaneous alarm: valid with no clock and during reset.
    logic alarm_now;
    assign alarm_now = |sensors;

    logic                 armed_reg;
    logic                 latched_reg, latched_next;
    logic [2:0]           cause_reg, cause_next;
    logic [BLINK_DIV-1:0] blink_cnt_reg;
    logic                 prev_now_reg;
    logic [7:0]           count_reg, count_next;

    // Trigger uses the registered arm, so arming takes effect one edge late.
    logic trigger;
    assign trigger = armed_reg & alarm_now;

    // Clear wins over a simultaneous trigger; the latch re-sets on the first
    // edge after clear drops if the trigger condition still holds.
    assign latched_next = clear_in ? 1'b0 : (latched_reg | trigger);

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_cause
            assign cause_next[gi] = clear_in ? 1'b0
                                             : (cause_reg[gi] | (trigger & sensors[gi]));
        end
    endgenerate

    // Count rising edges of alarm_now while armed; stick at 255.
    always_comb begin
        count_next = count_reg;
        if (trigger && !prev_now_reg && (count_reg != 8'hFF)) begin
            count_next = count_reg + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            armed_reg     <= 1'b0;
            latched_reg   <= 1'b0;
            cause_reg     <= 3'b000;
            blink_cnt_reg <= '0;
            prev_now_reg  <= 1'b0;
            count_reg     <= 8'd0;
        end else begin
            armed_reg     <= arm_in;
            latched_reg   <= latched_next;
            cause_reg     <= cause_next;
            blink_cnt_reg <= blink_cnt_reg + 1'b1;
            prev_now_reg  <= alarm_now;
            count_reg     <= count_next;
        end
    end

    // Siren follows the counter MSB, gated by the latch.
    logic siren;
    assign siren = latched_reg & blink_cnt_reg[BLINK_DIV-1];

    assign uo_out  = {1'b0, siren, armed_reg, cause_reg, latched_reg, alarm_now};
    assign uio_out = count_reg;
    assign uio_oe  = 8'hFF;

endmodule

// File: tb/tb_tt_um_umar316798.sv
module tb_tt_um_umar316798;

    localparam int BLINK_DIV = 4;
    localparam int PERIOD    = 1 << BLINK_DIV;

    logic       clk;
    logic       clk_run;
    logic       rst_n;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic       ena;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    tt_um_umar316798 #(.BLINK_DIV(BLINK_DIV)) dut (
        .ui_in  (ui_in),
        .uo_out (uo_out),
        .uio_in (uio_in),
        .uio_out(uio_out),
        .uio_oe (uio_oe),
        .ena    (ena),
        .clk    (clk),
        .rst_n  (rst_n)
    );

    always begin
        #5;
        if (clk_run) clk = ~clk;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Behavioural model: alarm state in plain terms, siren from the number of
    // cycles elapsed since reset.
    bit       m_armed;
    bit       m_latched;
    bit [2:0] m_cause;
    int       m_cycles;
    bit       m_prev;
    int       m_events;

    task automatic model_edge(input logic [7:0] ui, input logic rst);
        bit now;
        now = (ui[2:0] != 3'b000);
        if (rst) begin
            m_armed = 0; m_latched = 0; m_cause = 0;
            m_cycles = 0; m_prev = 0; m_events = 0;
        end else begin
            if (ui[4]) begin
                m_latched = 0;
                m_cause   = 0;
            end else if (m_armed && now) begin
                m_latched = 1;
                m_cause   = m_cause | ui[2:0];
            end
            if (m_armed && now && !m_prev && m_events < 255) m_events++;
            m_prev   = now;
            m_armed  = ui[3];
            m_cycles = m_cycles + 1;
        end
    endtask

    function automatic logic [7:0] model_uo(input logic [7:0] ui);
        bit siren;
        siren = m_latched && ((m_cycles % PERIOD) >= PERIOD / 2);
        return {1'b0, siren, m_armed, m_cause, m_latched, ui[2:0] != 3'b000};
    endfunction

    // One clock: drive at negedge, check the combinational alarm, then check
    // every output against the model just after the rising edge.
    task automatic step(input logic [7:0] ui, input logic rst);
        @(negedge clk);
        ui_in = ui;
        rst_n = rst;
        #1 check("alarm_now_comb", {7'd0, uo_out[0]}, {7'd0, ui[2:0] != 3'b000});
        @(posedge clk);
        model_edge(ui, rst);
        #1;
        check("uo_out", uo_out, model_uo(ui));
        check("uio_out", uio_out, 8'(m_events));
        check("uio_oe", uio_oe, 8'hFF);
    endtask

    typedef struct {
        logic [7:0] ui;
        logic       rst;
        logic [7:0] exp_uo;
        logic [7:0] exp_cnt;
    } vec_t;

    vec_t vecs[19];
    logic siren_hist[64];
    int   highs;

    initial begin
        clk = 0; clk_run = 0; rst_n = 1; ui_in = 0; uio_in = 8'hA5; ena = 0;

        // Combinational alarm with no clock running and reset held.
        for (int i = 0; i < 8; i++) begin
            ui_in = 8'(i);
            #1 check("alarm_noclk", {7'd0, uo_out[0]}, {7'd0, i != 0});
            #9;
        end

        clk_run = 1;

        // Hand-computed sequence: reset, arm, door pulse, clear, disarm,
        // reset, then disarmed motion toggling.
        vecs[0] = '{8'h00, 1'b1, 8'h00, 8'd0};
        vecs[1] = '{8'h00, 1'b1, 8'h00, 8'd0};
        vecs[2] = '{8'h08, 1'b0, 8'h20, 8'd0};
        vecs[3] = '{8'h08, 1'b0, 8'h20, 8'd0};
        vecs[4] = '{8'h0A, 1'b0, 8'h2B, 8'd1};
        vecs[5] = '{8'h08, 1'b0, 8'h2A, 8'd1};
        vecs[6] = '{8'h18, 1'b0, 8'h20, 8'd1};
        vecs[7] = '{8'h00, 1'b0, 8'h00, 8'd1};
        vecs[8] = '{8'h00, 1'b1, 8'h00, 8'd0};
        for (int i = 0; i < 10; i++) begin
            vecs[9 + i] = '{(i % 2 == 0) ? 8'h01 : 8'h00, 1'b0,
                            (i % 2 == 0) ? 8'h01 : 8'h00, 8'd0};
        end
        for (int i = 0; i < 19; i++) begin
            step(vecs[i].ui, vecs[i].rst);
            check($sformatf("vec%0d_uo", i), uo_out, vecs[i].exp_uo);
            check($sformatf("vec%0d_cnt", i), uio_out, vecs[i].exp_cnt);
        end

        // Clear while window held and armed: clear edge wins, re-latch after.
        step(8'h00, 1'b1);
        step(8'h08, 1'b0);
        step(8'h0C, 1'b0);
        check("pre_clear_latch", {6'd0, uo_out[4], uo_out[1]}, 8'h03);
        step(8'h1C, 1'b0);
        check("clear_edge", {6'd0, uo_out[4], uo_out[1]}, 8'h00);
        step(8'h0C, 1'b0);
        check("relatch", {6'd0, uo_out[4], uo_out[1]}, 8'h03);

        // Siren blink: 64 latched cycles, halves of PERIOD/2 alternate.
        highs = 0;
        for (int i = 0; i < 64; i++) begin
            step(8'h0C, 1'b0);
            siren_hist[i] = uo_out[6];
            if (uo_out[6]) highs++;
        end
        for (int i = PERIOD / 2; i < 64; i++) begin
            check($sformatf("blink_toggle%0d", i),
                  {7'd0, siren_hist[i]}, {7'd0, ~siren_hist[i - PERIOD / 2]});
        end
        check("blink_high_count", 8'(highs), 8'd32);

        // Saturation after 300 motion rising edges while armed, then reset.
        step(8'h00, 1'b1);
        step(8'h08, 1'b0);
        for (int i = 0; i < 300; i++) begin
            step(8'h09, 1'b0);
            step(8'h08, 1'b0);
        end
        check("saturated", uio_out, 8'd255);
        step(8'h09, 1'b0);
        step(8'h09, 1'b1);
        check("reset_uo", {2'b00, uo_out[6:1]}, 8'h00);
        check("reset_cnt", uio_out, 8'd0);

        // Randomised traffic against the model.
        for (int i = 0; i < 2000; i++) begin
            logic [7:0] ui;
            logic       rst;
            ui = 8'($urandom);
            ui[4] = ($urandom_range(0, 15) == 0);
            ui[3] = ($urandom_range(0, 7) != 0);
            rst = ($urandom_range(0, 199) == 0);
            step(ui, rst);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tt_um_umar316798.md
Name: tt_um_umar316798

Overview:
Intrusion-alarm block in the standard Tiny Tapeout user-project wrapper. Three sensor inputs (motion, door, window) drive an instantaneous combinational alarm. The registered logic adds arm control, a latched alarm with per-sensor cause flags, a blinking siren output and a saturating trigger-event counter.

Parameters:
BLINK_DIV, 4, siren blink period is 2^BLINK_DIV cycles (half high, half low); legal range 1..8.

Ports:
clk  input  1  system clock; all registers update on its rising edge
rst_n  input  1  synchronous, active-high reset (1 = reset); the port name is kept from the wrapper template
ui_in  input  8  [0]=motion, [1]=door, [2]=window, [3]=arm, [4]=clear; [7:5] ignored
uo_out  output  8  [0]=alarm_now, [1]=alarm_latched, [2]=motion_cause, [3]=door_cause, [4]=window_cause, [5]=armed, [6]=siren, [7]=0
uio_in  input  8  unused, ignored
uio_out  output  8  trigger-event counter value
uio_oe  output  8  constant 8'hFF
ena  input  1  ignored; the design is always active

Behaviour:
- alarm_now: uo_out[0] = ui_in[0] | ui_in[1] | ui_in[2].
  - Purely combinational; independent of clk, rst_n, arm and ena.
  - Valid with no clock running and while reset is held.
  - Truth table: 000->0; every other combination ->1.
- armed: uo_out[5] = registered copy of ui_in[3]. One-cycle latency. Reset value 0.
- Trigger condition, evaluated at each rising edge: armed (registered) = 1 and alarm_now = 1.
- alarm_latched (uo_out[1]):
  - Set to 1 on the edge where the trigger condition holds.
  - Holds until clear or reset. Disarming does not clear it.
- Cause flags (uo_out[4:2]):
  - On a trigger edge, each flag ORs in its own sensor bit.
  - A flag is set only if that sensor is high on a trigger edge.
  - Flags hold until clear or reset.
- clear (ui_in[4], sampled at the edge): clears alarm_latched and all three cause flags.
  - Clear has priority over a trigger in the same cycle.
  - If sensors remain active while armed, the latch sets again on the next edge after clear deasserts.
- siren (uo_out[6]) = alarm_latched & blink_cnt[BLINK_DIV-1].
  - blink_cnt is a free-running BLINK_DIV-bit counter, reset to 0.
  - While latched, the first high phase starts 2^(BLINK_DIV-1) cycles after reset.
  - siren is 0 whenever alarm_latched = 0.
- Event counter (uio_out):
  - An internal register prev_now holds the last-cycle value of alarm_now.
  - Counter increments by 1 when armed & alarm_now & !prev_now, i.e. on each rising edge of alarm_now while armed.
  - Saturates at 255; no wrap-around.
  - Cleared only by reset; clear does not affect it.
- uo_out[7] = 0 and uio_oe = 8'hFF at all times.
- Reset (rst_n = 1 at a rising edge) forces to 0: armed, alarm_latched, cause flags, blink_cnt, prev_now, counter.
  - Reset mid-alarm kills the latch and siren in the same edge.
  - alarm_now keeps following the sensors during reset.
- All register outputs are glitch-free, changing only on rising clk edges.

Test Plan:
- No clock, rst_n = 1, ui_in stepped 0..7 every 10 time units -> uo_out[0] = 0,1,1,1,1,1,1,1.
- Reset 2 cycles, release, arm = 1, wait 1 cycle, pulse door = 1 for 1 cycle -> after that edge: uo_out[1] = 1, uo_out[3] = 1, uo_out[2] = uo_out[4] = 0, uio_out = 1.
- Disarmed (arm = 0), toggle motion 5 times -> uo_out[0] follows motion; uo_out[1] = 0; uio_out = 0.
- Latched alarm, assert clear while window = 1 and armed -> latch and flags = 0 on the clear edge; re-set to uo_out[1] = 1, uo_out[4] = 1 on the first edge after clear drops.
- Latched alarm held for 64 cycles with BLINK_DIV = 4 -> uo_out[6] alternates 8 cycles low / 8 cycles high.
- Armed, produce 300 motion rising edges -> uio_out saturates at 255; then assert reset -> all of uo_out[6:1] = 0 and uio_out = 0.
